// File: rtl/sr_cmd_pkg.sv
// Shared encodings for the SR command sequencer: command ops, FSM states,
// and the helper that sizes the shared phase counter.
package sr_cmd_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // The counter must hold PULSE_W-1 and GAP_W-1; a floor of 2 keeps it at least 1 bit wide.
  function automatic int calc_cnt_w(input int pulse_w, input int gap_w);
    int m;
    m = 2;
    if (pulse_w > m) m = pulse_w;
    if (gap_w > m) m = gap_w;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the DRIVE and GAP phases of the sequencer.
// Load wins over enable; the count holds at zero.
module sr_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command stage for the JK-based SR flip-flop: turns set/reset/toggle/nop commands
// into timed, mutually exclusive s/r pulses. Optional drive counter: SR_CMD_STATS_EN.
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  output logic       q_shadow,
`ifdef SR_CMD_STATS_EN
  output logic [7:0] drive_cnt,
`endif
  output logic       busy
);

  localparam int CNT_W = calc_cnt_w(PULSE_W, GAP_W);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  state_e           state_q;
  logic             s_q;
  logic             r_q;
  logic             shadow_q;
  logic             tgt_q;
  logic             start;
  logic             set_sel;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign start     = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
  // Toggle resolves against the shadow so the flip-flop never sees s=r=1.
  assign set_sel   = (cmd_op == OP_SET) || ((cmd_op == OP_TOGGLE) && !shadow_q);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          if (GAP_W > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_GAP:  tmr_en = 1'b1;
      default: ;
    endcase
  end

  sr_pulse_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      shadow_q <= 1'b0;
      tgt_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_DRIVE;
            s_q     <= set_sel;
            r_q     <= !set_sel;
            tgt_q   <= set_sel;
          end
        end
        ST_DRIVE: begin
          if (tmr_zero) begin
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            shadow_q <= tgt_q;
            state_q  <= (GAP_W > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (tmr_zero) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign q_shadow = shadow_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef SR_CMD_STATS_EN
  logic [7:0] drive_cnt_q;
  logic [7:0] drive_cnt_d;

  always_comb begin
    drive_cnt_d = drive_cnt_q;
    if (start && (drive_cnt_q != 8'hFF)) drive_cnt_d = drive_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drive_cnt_q <= 8'h00;
    else     drive_cnt_q <= drive_cnt_d;
  end

  assign drive_cnt = drive_cnt_q;
`endif

endmodule
